pe_row_sched: RTL and testbench

Sequencer for the 32-lane PE row and its 2-stage adder tree. For each output channel (kernel) it fetches the weights, pulses `new_weight_val`, streams every output position through the sliding-window buffer, and drains the row pipeline. It tags each row result with its channel and position, and optionally applies ReLU. It sits between the layer controller (start/done), the weight SRAM, the slide-data buffer and the PE row.

---
 rtl/pe_row_sched.sv | 149 ++++++++++++++
 tb/tb_pe_row_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pe_row_sched.sv
// Per-kernel sequencer for the 32-lane PE row: weight fetch, window streaming, pipeline drain, tagged results.
// Optional ReLU on the result path is enabled by defining PE_ROW_SCHED_RELU_EN.
module pe_row_sched #(
  parameter int N_OCH    = 16,
  parameter int N_POS    = 64,
  parameter int PIPE_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       wgt_rd_en,
  output logic [$clog2(N_OCH)-1:0]   wgt_addr,
  output logic                       new_weight_val,
  input  logic                       dat_valid,
  output logic                       slide_en,
  input  logic signed [8:0]          row_result,
  output logic signed [8:0]          res_out,
  output logic                       res_val,
  output logic [$clog2(N_OCH)-1:0]   res_och,
  output logic [$clog2(N_POS)-1:0]   res_pos
);
  localparam int OCH_W = $clog2(N_OCH);
  localparam int POS_W = $clog2(N_POS);
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WR, STREAM, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [OCH_W-1:0]   och;
  logic [POS_W-1:0]   pos;
  logic [CNT_W-1:0]   dcnt;
  logic               last_pos, last_och, drain_end;
  logic signed [8:0]  res_d;

  logic               tag_v   [PIPE_LAT];
  logic [OCH_W-1:0]   tag_och [PIPE_LAT];
  logic [POS_W-1:0]   tag_pos [PIPE_LAT];

  assign last_pos  = (pos == POS_W'(N_POS - 1));
  assign last_och  = (och == OCH_W'(N_OCH - 1));
  assign drain_end = (dcnt == CNT_W'(PIPE_LAT - 1));
  assign wgt_addr  = och;

  always_comb begin
    state_nx       = state;
    busy           = (state != IDLE);
    wgt_rd_en      = 1'b0;
    new_weight_val = 1'b0;
    slide_en       = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = LOAD_REQ;
      LOAD_REQ: begin
        wgt_rd_en = 1'b1;
        state_nx  = LOAD_WR;
      end
      LOAD_WR: begin
        new_weight_val = 1'b1;
        state_nx       = STREAM;
      end
      STREAM: begin
        slide_en = dat_valid;
        if (dat_valid && last_pos) state_nx = DRAIN;
      end
      DRAIN:    if (drain_end) state_nx = last_och ? DONE : LOAD_REQ;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      och  <= '0;
      pos  <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          och  <= '0;
          pos  <= '0;
          dcnt <= '0;
        end
        STREAM: if (slide_en) pos <= last_pos ? '0 : pos + 1'b1;
        DRAIN: begin
          if (drain_end) begin
            dcnt <= '0;
            if (!last_och) och <= och + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags shift every cycle; non-slide cycles insert bubbles so the row pipeline and tags stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_och[i] <= '0;
        tag_pos[i] <= '0;
      end
    end else begin
      tag_v[0]   <= slide_en;
      tag_och[0] <= och;
      tag_pos[0] <= pos;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_och[i] <= tag_och[i-1];
        tag_pos[i] <= tag_pos[i-1];
      end
    end
  end

`ifdef PE_ROW_SCHED_RELU_EN
  assign res_d = row_result[8] ? '0 : row_result;
`else
  assign res_d = row_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out <= '0;
      res_val <= 1'b0;
      res_och <= '0;
      res_pos <= '0;
    end else begin
      res_val <= tag_v[PIPE_LAT-1];
      if (tag_v[PIPE_LAT-1]) begin
        res_out <= res_d;
        res_och <= tag_och[PIPE_LAT-1];
        res_pos <= tag_pos[PIPE_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_pe_row_sched.sv
// Directed bench for pe_row_sched with N_OCH=2, N_POS=4, PIPE_LAT=3; expected cycles/tags hand-derived.
module tb_pe_row_sched;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, wgt_rd_en, new_weight_val, slide_en, res_val;
  logic [0:0]        wgt_addr, res_och;
  logic [1:0]        res_pos;
  logic              dat_valid = 1'b0;
  logic signed [8:0] row_result = '0;
  logic signed [8:0] res_out;

  int n_checks = 0;
  int n_errors = 0;
  int inflight;
  int nbusy;
  int rd_q[$], rd_addr_q[$], nwv_q[$], done_q[$], slide_q[$];
  int res_q[$], res_och_q[$], res_pos_q[$], res_val_q[$];

  pe_row_sched #(.N_OCH(2), .N_POS(4), .PIPE_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .new_weight_val(new_weight_val),
    .dat_valid(dat_valid), .slide_en(slide_en), .row_result(row_result),
    .res_out(res_out), .res_val(res_val), .res_och(res_och), .res_pos(res_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({busy, done, wgt_rd_en, new_weight_val, slide_en, res_val,
                 wgt_addr, res_out, res_och, res_pos});
  endfunction

  // Stimulus value on row_result during cycle c (drives the window slid at c-3).
  function automatic int rr_model(input int c, input bit cst);
    return cst ? -5 : 5 * c - 40;
  endfunction

  function automatic int exp_res(input int c, input bit cst);
    int v;
    v = rr_model(c - 1, cst);
`ifdef PE_ROW_SCHED_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  // Pulses start before edge 0, then observes cycles 1..26 at mid-cycle.
  task automatic run(input logic [31:0] stall_m, input logic [31:0] start_m,
                     input bit cst, input int rst_cyc);
    rd_q.delete(); rd_addr_q.delete(); nwv_q.delete(); done_q.delete(); slide_q.delete();
    res_q.delete(); res_och_q.delete(); res_pos_q.delete(); res_val_q.delete();
    inflight = 0;
    nbusy    = 0;
    @(negedge clk);
    start = 1'b1; dat_valid = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      dat_valid  = !stall_m[c];
      start      = start_m[c];
      row_result = 9'(rr_model(c, cst));
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1 check("rst_mid_outs", all_outs(), 0);
        break;
      end
      #1;
      if (wgt_rd_en) begin
        rd_q.push_back(c);
        rd_addr_q.push_back(int'(wgt_addr));
      end
      if (new_weight_val) begin
        check("wgt_stable_inflight", inflight, 0);
        nwv_q.push_back(c);
      end
      if (slide_en) begin
        slide_q.push_back(c);
        inflight++;
      end
      if (res_val) begin
        res_q.push_back(c);
        res_och_q.push_back(int'(res_och));
        res_pos_q.push_back(int'(res_pos));
        res_val_q.push_back(int'(res_out));
        inflight--;
      end
      if (done) done_q.push_back(c);
      if (busy) nbusy++;
    end
    start = 1'b0;
  endtask

  task automatic verify(input int e_rd[2], input int e_done, input int e_slide[8],
                        input int e_res[8], input bit cst);
    check("rd_count", rd_q.size(), 2);
    check("nwv_count", nwv_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < rd_q.size()) begin
        check("rd_cycle", rd_q[i], e_rd[i]);
        check("rd_addr", rd_addr_q[i], i);
      end
      if (i < nwv_q.size()) check("nwv_cycle", nwv_q[i], e_rd[i] + 1);
    end
    check("done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cycle", done_q[0], e_done);
    check("busy_cycles", nbusy, e_done);
    check("slide_count", slide_q.size(), 8);
    check("res_count", res_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < slide_q.size()) check("slide_cycle", slide_q[i], e_slide[i]);
      if (i < res_q.size()) begin
        check("res_cycle", res_q[i], e_res[i]);
        check("res_och", res_och_q[i], i / 4);
        check("res_pos", res_pos_q[i], i % 4);
        check("res_out", res_val_q[i], exp_res(e_res[i], cst));
      end
    end
    if (done_q.size() > 0 && res_q.size() > 0)
      check("last_res_with_done", res_q[res_q.size()-1], done_q[0]);
  endtask

  initial begin
    int rd_a[2]    = '{1, 10};
    int sl_a[8]    = '{3, 4, 5, 6, 12, 13, 14, 15};
    int rs_a[8]    = '{7, 8, 9, 10, 16, 17, 18, 19};
    int rd_b[2]    = '{1, 12};
    int sl_b[8]    = '{3, 6, 7, 8, 14, 15, 16, 17};
    int rs_b[8]    = '{7, 10, 11, 12, 18, 19, 20, 21};
    logic [31:0] stall_b;
    logic [31:0] start_d;

    stall_b = '0;
    stall_b[4] = 1'b1;
    stall_b[5] = 1'b1;
    start_d = '0;
    start_d[4]  = 1'b1;
    start_d[19] = 1'b1;

    repeat (3) @(posedge clk);
    #1 check("reset_outs", all_outs(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run('0, '0, 1'b0, 0);
    verify(rd_a, 19, sl_a, rs_a, 1'b0);

    run(stall_b, '0, 1'b0, 0);
    verify(rd_b, 21, sl_b, rs_b, 1'b0);

    run('0, '0, 1'b1, 0);
    verify(rd_a, 19, sl_a, rs_a, 1'b1);

    run('0, start_d, 1'b0, 0);
    verify(rd_a, 19, sl_a, rs_a, 1'b0);

    run('0, '0, 1'b0, 8);
    repeat (2) @(negedge clk);
    #1 check("rst_hold_outs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run('0, '0, 1'b0, 0);
    verify(rd_a, 19, sl_a, rs_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
